// File: rtl/fifo_pkg.sv
// Project-wide default geometry for the first-word-fall-through input queue.
package fifo_pkg;
  localparam int DEFAULT_NUM_SLOTS     = 4;
  localparam int DEFAULT_LOG_NUM_SLOTS = 2;
  localparam int DEFAULT_DATA_WIDTH    = 8;
endpackage

// File: rtl/fifo_mem.sv
// Register array: synchronous write, asynchronous read, synchronous active-low clear.
// Latency: write visible on rd_dat the cycle after the edge; no backpressure (caller gates wr_en).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int NUM_SLOTS     = DEFAULT_NUM_SLOTS,
  parameter int LOG_NUM_SLOTS = DEFAULT_LOG_NUM_SLOTS,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [LOG_NUM_SLOTS-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_dat,
  input  logic [LOG_NUM_SLOTS-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_dat
);

  logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] mem;

  // Clear wins over write so a request in the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fifo.sv
// Synchronous FWFT FIFO; head word shown combinationally on data_read. Optional checks: FIFO_CHECK_EN.
// Latency: write at edge t readable in cycle t+1; writes while full and reads while empty are dropped.
module fifo
  import fifo_pkg::*;
#(
  parameter int NUM_SLOTS     = DEFAULT_NUM_SLOTS,
  parameter int LOG_NUM_SLOTS = DEFAULT_LOG_NUM_SLOTS,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam logic [LOG_NUM_SLOTS:0]   CNT_FULL = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0]   CNT_ONE  = (LOG_NUM_SLOTS+1)'(1);
  localparam logic [LOG_NUM_SLOTS-1:0] PTR_ONE  = LOG_NUM_SLOTS'(1);

  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [LOG_NUM_SLOTS:0]   count;
  logic                     wr_acc;
  logic                     rd_acc;

  // Flags come only from the registered count, so no same-cycle pass-through.
  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign almost_full = (count >= CNT_FULL - CNT_ONE);

  assign wr_acc = write & ~full;
  assign rd_acc = next_read & ~empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .NUM_SLOTS    (NUM_SLOTS),
    .LOG_NUM_SLOTS(LOG_NUM_SLOTS),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_dat (data_write),
    .rd_addr(rd_ptr),
    .rd_dat (data_read)
  );

`ifdef FIFO_CHECK_EN
  int unsigned cycle_cnt;

  initial begin
    if (NUM_SLOTS != (1 << LOG_NUM_SLOTS))
      $display("ERROR fifo: NUM_SLOTS=%0d is not 2**LOG_NUM_SLOTS=%0d", NUM_SLOTS, 1 << LOG_NUM_SLOTS);
  end

  always @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= 0;
    end else begin
      cycle_cnt <= cycle_cnt + 1;
      if (write && full)
        $display("ERROR fifo: write while full at cycle %0d", cycle_cnt);
      if (next_read && empty)
        $display("ERROR fifo: read while empty at cycle %0d", cycle_cnt);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed walk through the fill/overflow/wrap/underflow/reset cases, then random traffic vs a queue model.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_write;
  logic       write;
  logic       full;
  logic       almost_full;
  logic [7:0] data_read;
  logic       next_read;
  logic       empty;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [7:0] model_q[$];
  bit         have_reset = 1'b0;
  int unsigned writes_since_reset = 0;

  always #5 clk = ~clk;

  fifo #(.NUM_SLOTS(4), .LOG_NUM_SLOTS(2), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_write (data_write),
    .write      (write),
    .full       (full),
    .almost_full(almost_full),
    .data_read  (data_read),
    .next_read  (next_read),
    .empty      (empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare outputs against the model, apply one clock, then advance the model.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic rs);
    bit wacc, racc;
    write = w; data_write = d; next_read = r; rst = rs;
    #1;
    if (have_reset) begin
      check_eq("empty",       empty,       model_q.size() == 0);
      check_eq("full",        full,        model_q.size() == 4);
      check_eq("almost_full", almost_full, model_q.size() >= 3);
      if (model_q.size() > 0)
        check_eq("data_read", data_read, model_q[0]);
      else if (writes_since_reset == 0)
        check_eq("data_read_clear", data_read, 8'h00);
    end
    @(posedge clk);
    #1;
    if (!rs) begin
      model_q.delete();
      writes_since_reset = 0;
      have_reset = 1'b1;
    end else begin
      wacc = w && (model_q.size() < 4);
      racc = r && (model_q.size() > 0);
      if (racc) void'(model_q.pop_front());
      if (wacc) begin
        model_q.push_back(d);
        writes_since_reset++;
      end
    end
  endtask

  initial begin
    write = 1'b0; data_write = '0; next_read = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);

    // Idle after reset, then a single word in and out.
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'hA1, 0, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);

    // Fill, overflow attempt, drain.
    cycle(1, 8'h11, 0, 1);
    cycle(1, 8'h22, 0, 1);
    cycle(1, 8'h33, 0, 1);
    cycle(1, 8'h44, 0, 1);
    cycle(1, 8'h55, 0, 1);
    cycle(1, 8'h66, 1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 1);

    // Streaming with read held high across pointer wrap.
    for (int i = 1; i <= 10; i++) cycle(1, 8'(i), 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 1);

    // Underflow, then reset with two words stored and requests pending.
    cycle(0, 8'h00, 1, 1);
    cycle(1, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(1, 8'hC1, 0, 1);
    cycle(1, 8'hC2, 0, 1);
    cycle(1, 8'h77, 1, 0);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 1);

    // Random traffic with occasional mid-operation reset.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 55,
            8'($urandom),
            $urandom_range(99) < 50,
            !($urandom_range(199) == 0));
    end
    cycle(0, 8'h00, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
